// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: per-beat bitwise logic op with an optional accumulator
// feeding operand B. One output register stage sits behind a valid/ready
// handshake and supports full backpressure.

// One result bit. The top instantiates one of these per bit position.
module logic_unit_bit (
  input  logic       a,
  input  logic       b,
  input  logic [2:0] op,
  output logic       y
);
  // Decode the op for this bit position.
  always_comb begin
    case (op)
      3'd0:    y = a & b;
      3'd1:    y = a | b;
      3'd2:    y = ~a;
      3'd3:    y = ~(a & b);
      3'd4:    y = ~(a | b);
      3'd5:    y = a ^ b;
      3'd6:    y = ~(a ^ b);
      default: y = a;
    endcase
  end
endmodule

module logic_unit_pipe #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_parity,
  output logic [WIDTH-1:0] acc_q
);
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             accept;

  // The output slot can take a beat if it is empty or being drained this cycle.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign opb      = in_acc ? acc : in_b;
  assign acc_q    = acc;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    logic_unit_bit u_bit (
      .a  (in_a[i]),
      .b  (opb[i]),
      .op (in_op),
      .y  (res[i])
    );
  end

  // Output register: load on accept, otherwise drop valid once consumed.
  // Registers only ever load from res on accept, so idle input values never
  // reach state.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_y      <= '0;
      out_zero   <= 1'b0;
      out_parity <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_y      <= res;
      out_zero   <= (res == '0);
      out_parity <= ^res;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Accumulator tracks every accepted result; a clear in the same cycle wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= ACC_INIT;
    end else if (acc_clr) begin
      acc <= ACC_INIT;
    end else if (accept) begin
      acc <= res;
    end
  end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: an 8-bit instance for directed and
// random backpressure traffic and a 13-bit instance for a streaming run.
module tb_logic_unit_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // 8-bit instance
  logic       rst, in_valid, in_ready, in_acc, acc_clr, out_valid, out_ready, out_zero, out_parity;
  logic [7:0] in_a, in_b, out_y, acc_q;
  logic [2:0] in_op;

  logic_unit_pipe #(.WIDTH(8)) d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_zero(out_zero), .out_parity(out_parity), .acc_q(acc_q)
  );

  // 13-bit instance
  logic        w_in_valid, w_in_ready, w_in_acc, w_acc_clr, w_out_valid, w_out_ready, w_out_zero, w_out_parity;
  logic [12:0] w_in_a, w_in_b, w_out_y, w_acc_q;
  logic [2:0]  w_in_op;

  logic_unit_pipe #(.WIDTH(13)) d13 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(w_in_a), .in_b(w_in_b), .in_op(w_in_op), .in_acc(w_in_acc), .acc_clr(w_acc_clr),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_y(w_out_y),
    .out_zero(w_out_zero), .out_parity(w_out_parity), .acc_q(w_acc_q)
  );

  // Reference model state
  logic [15:0] exp_q8[$];
  logic [15:0] exp_q13[$];
  logic [15:0] m_acc = '0;
  logic [15:0] m13_acc = '0;
  logic [15:0] last_y = '0;
  int n13 = 0, first13 = 0, last13 = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_op(input int op, input logic [15:0] a, input logic [15:0] b, input int w);
    logic [15:0] r;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2: r = ~a;
      3: r = ~(a & b);
      4: r = ~(a | b);
      5: r = a ^ b;
      6: r = ~(a ^ b);
      default: r = a;
    endcase
    return r & ((16'd1 << w) - 16'd1);
  endfunction

  // Monitor for the 8-bit instance: pops on consume, checks stall stability.
  logic       held = 1'b0;
  logic [7:0] held_y, held_z, held_p;
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && out_valid) begin
        chk("hold_y", out_y, held_y);
        chk("hold_zero", out_zero, held_z);
        chk("hold_parity", out_parity, held_p);
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", in_ready, 0);
        held = 1'b1; held_y = out_y; held_z = out_zero; held_p = out_parity;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q8.size() == 0) begin
          chk("unexpected_out8", 1, 0);
        end else begin
          e = exp_q8.pop_front();
          chk("out_y", out_y, e[7:0]);
          chk("out_zero", out_zero, (e[7:0] == 8'h00));
          chk("out_parity", out_parity, ^e[7:0]);
        end
      end
    end
  end

  // Monitor for the 13-bit instance: records arrival cycles for contiguity.
  always @(negedge clk) begin
    logic [15:0] e;
    cyc++;
    if (!rst && w_out_valid && w_out_ready) begin
      if (exp_q13.size() == 0) begin
        chk("unexpected_out13", 1, 0);
      end else begin
        e = exp_q13.pop_front();
        chk("w_out_y", w_out_y, e[12:0]);
        chk("w_out_zero", w_out_zero, (e[12:0] == 13'd0));
        chk("w_out_parity", w_out_parity, ^e[12:0]);
      end
      if (n13 == 0) first13 = cyc;
      last13 = cyc;
      n13++;
    end
  end

  // Present one beat until accepted; returns 2 time units after the accept edge.
  task automatic beat(input logic [7:0] a, input logic [7:0] b, input int op, input bit ua, input bit cl);
    bit rdy, taken;
    logic [15:0] y;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op[2:0]; in_acc = ua; acc_clr = cl;
    taken = 1'b0;
    for (int t = 0; t < 200 && !taken; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #2;
      if (rdy) begin
        y = ref_op(op, {8'h00, a}, ua ? m_acc : {8'h00, b}, 8);
        exp_q8.push_back(y);
        last_y = y;
        m_acc = cl ? 16'h0000 : y;
        taken = 1'b1;
      end
    end
    in_valid = 1'b0; acc_clr = 1'b0;
    if (!taken) chk("beat_timeout", 0, 1);
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q8.delete();
    m_acc = '0;
    held = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit done;
    rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_op = 0; in_acc = 0; acc_clr = 0; out_ready = 1;
    w_in_valid = 0; w_in_a = 0; w_in_b = 0; w_in_op = 0; w_in_acc = 0; w_acc_clr = 0; w_out_ready = 1;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_parity", out_parity, 0);
    chk("rst_acc_q", acc_q, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_w_out_valid", w_out_valid, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Op sweep, then all-zero operands
    for (int op = 0; op < 8; op++) beat(8'hF0, 8'h3C, op, 0, 0);
    beat(8'h00, 8'h00, 0, 0, 0);
    drain();
    chk("sweep_drained", exp_q8.size(), 0);

    // Accumulate chain
    pulse_reset();
    beat(8'h01, 8'h00, 1, 1, 0);
    beat(8'h02, 8'h00, 1, 1, 0);
    beat(8'h04, 8'h00, 1, 1, 0);
    chk("acc_chain", acc_q, m_acc[7:0]);
    beat(8'h05, 8'h00, 0, 1, 0);
    drain();
    acc_clr = 1'b1;
    @(posedge clk);
    #2;
    acc_clr = 1'b0;
    m_acc = '0;
    chk("acc_clr_idle", acc_q, m_acc[7:0]);
    chk("acc_clr_out_y", out_y, last_y[7:0]);
    chk("acc_clr_out_valid", out_valid, 0);

    // Clear together with an accumulating beat
    beat(8'h0F, 8'h00, 7, 0, 0);
    chk("acc_load", acc_q, m_acc[7:0]);
    beat(8'hFF, 8'h00, 5, 1, 1);
    chk("acc_clr_accept", acc_q, m_acc[7:0]);
    drain();
    chk("clr_drained", exp_q8.size(), 0);

    // Backpressure: three beats against a stalled consumer
    out_ready = 1'b0;
    fork
      begin
        beat(8'h11, 8'h00, 7, 0, 0);
        beat(8'h22, 8'h00, 7, 0, 0);
        beat(8'h33, 8'h00, 7, 0, 0);
      end
      begin
        @(posedge clk);
        repeat (4) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_drained", exp_q8.size(), 0);

    // Random beats with random consumer stalls
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          beat(8'($urandom), 8'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 1'b0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #2;
          out_ready = 1'($urandom);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("rand_drained", exp_q8.size(), 0);
    chk("rand_acc", acc_q, m_acc[7:0]);

    // Reset with a result stalled in the output register
    out_ready = 1'b0;
    beat(8'hAA, 8'h00, 7, 0, 0);
    chk("pre_rst_acc", acc_q, 8'hAA);
    pulse_reset();
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_y", out_y, 0);
    chk("mid_rst_acc_q", acc_q, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #2;
    out_ready = 1'b1;

    // Streaming throughput on the 13-bit instance
    m13_acc = '0;
    w_in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      int op;
      logic [15:0] a, b, y;
      op = int'($urandom_range(0, 7));
      a = 16'($urandom) & 16'h1FFF;
      b = 16'($urandom) & 16'h1FFF;
      w_in_a = a[12:0]; w_in_b = b[12:0]; w_in_op = op[2:0]; w_in_acc = 1'($urandom);
      @(negedge clk);
      chk("w_in_ready", w_in_ready, 1);
      @(posedge clk);
      y = ref_op(op, a, w_in_acc ? m13_acc : b, 13);
      exp_q13.push_back(y);
      m13_acc = y;
      #2;
    end
    w_in_valid = 1'b0;
    drain();
    chk("w_count", n13, 16);
    chk("w_contiguous", last13 - first13, 15);
    chk("w_drained", exp_q13.size(), 0);
    chk("w_acc", w_acc_q, m13_acc[12:0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
